// File: rtl/regfile_rat_pkg.sv
// Shared defaults, constants and typedefs for the integer register file / rename table.
package regfile_rat_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned TAG_W_DEF = 4;
    localparam int unsigned NRD_DEF   = 2;

    localparam logic [XLEN_DEF-1:0] ZeroWord  = '0;
    localparam logic                RstEnable = 1'b0;

    typedef logic [TAG_W_DEF-1:0] tag_t;
    typedef logic [AW_DEF-1:0]    reg_addr_t;

endpackage

// File: rtl/regfile_rat_rdport.sv
// One combinational read channel: x0 forced to zero, then same-cycle commit bypass, then stored entry.
module regfile_rat_rdport
    import regfile_rat_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic [AW-1:0]    raddr,
    input  logic [XLEN-1:0]  st_data,
    input  logic             st_busy,
    input  logic [TAG_W-1:0] st_tag,
    input  logic             cen,
    input  logic [AW-1:0]    c_addr,
    input  logic [TAG_W-1:0] c_tag,
    input  logic [XLEN-1:0]  c_data,
    output logic [XLEN-1:0]  data_c,
    output logic             busy_c,
    output logic [TAG_W-1:0] tag_c
);

    always_comb begin : rd_sel
        data_c = st_data;
        busy_c = st_busy;
        tag_c  = st_tag;
        if (raddr == '0) begin
            data_c = XLEN'(ZeroWord);
            busy_c = 1'b0;
            tag_c  = '0;
        end else if (cen && (c_addr == raddr) && st_busy && (st_tag == c_tag)) begin
            // Producer is retiring this cycle: hand its value straight to the reader.
            data_c = c_data;
            busy_c = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_rat.sv
// Integer register file with per-register busy bit and ROB producer tag (rename table).
// Optional busy-register counter enabled by defining REGFILE_RAT_BUSYCNT_EN.
module regfile_rat
    import regfile_rat_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned NRD   = NRD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    output logic [NRD*TAG_W-1:0]  rtag,
    input  logic                  ren,
    input  logic [AW-1:0]         rn_addr,
    input  logic [TAG_W-1:0]      rn_tag,
    input  logic                  cen,
    input  logic [AW-1:0]         c_addr,
    input  logic [TAG_W-1:0]      c_tag,
    input  logic [XLEN-1:0]       c_data,
    input  logic                  flush,
    output logic [NREG-1:0]       busy_vec
`ifdef REGFILE_RAT_BUSYCNT_EN
    ,
    output logic [AW:0]           busy_cnt
`endif
);

    logic [XLEN-1:0]  value_q [NREG];
    logic [XLEN-1:0]  value_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [TAG_W-1:0] tag_q   [NREG];
    logic [TAG_W-1:0] tag_d   [NREG];

    logic commit_v;
    logic rename_v;
    logic same_reg;
    logic commit_clr;

    // Qualified requests; x0 is never written and rdy=0 freezes everything.
    always_comb begin : req_decode
        commit_v   = rdy && cen && (c_addr != '0);
        rename_v   = rdy && ren && !flush && (rn_addr != '0);
        same_reg   = rename_v && (rn_addr == c_addr);
        commit_clr = commit_v && !same_reg && (tag_q[c_addr] == c_tag);
    end

    always_comb begin : next_state
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (commit_v) begin
            value_d[c_addr] = c_data;
            if (commit_clr) begin
                busy_d[c_addr] = 1'b0;
            end
        end
        if (rename_v) begin
            busy_d[rn_addr] = 1'b1;
            tag_d[rn_addr]  = rn_tag;
        end
        if (rdy && flush) begin
            busy_d = '0;
            for (int i = 0; i < int'(NREG); i++) begin
                tag_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin : state_regs
        if (rst == RstEnable) begin
            for (int i = 0; i < int'(NREG); i++) begin
                value_q[i] <= XLEN'(ZeroWord);
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[k*AW +: AW];

        regfile_rat_rdport #(
            .XLEN  (XLEN),
            .AW    (AW),
            .TAG_W (TAG_W)
        ) u_rdport (
            .raddr   (ra),
            .st_data (value_q[ra]),
            .st_busy (busy_q[ra]),
            .st_tag  (tag_q[ra]),
            .cen     (cen),
            .c_addr  (c_addr),
            .c_tag   (c_tag),
            .c_data  (c_data),
            .data_c  (rdata[k*XLEN +: XLEN]),
            .busy_c  (rbusy[k]),
            .tag_c   (rtag[k*TAG_W +: TAG_W])
        );
    end

`ifdef REGFILE_RAT_BUSYCNT_EN
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0] busy_cnt_q;
    logic [CW-1:0] busy_cnt_d;
    logic          cnt_inc;
    logic          cnt_dec;

    // Tracks popcount(busy_q) incrementally: at most one set and one clear per cycle.
    always_comb begin : cnt_next
        cnt_inc    = rename_v && !busy_q[rn_addr];
        cnt_dec    = commit_clr && busy_q[c_addr];
        busy_cnt_d = busy_cnt_q;
        if (rdy && flush) begin
            busy_cnt_d = '0;
        end else begin
            busy_cnt_d = busy_cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
        end
    end

    always_ff @(posedge clk or negedge rst) begin : cnt_reg
        if (rst == RstEnable) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_rat.sv
// Self-checking bench for regfile_rat: directed scenarios plus randomized traffic against an array model.
module tb_regfile_rat;
    import regfile_rat_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NRD   = 2;

    logic                 clk;
    logic                 rst;
    logic                 rdy;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic [NRD*TAG_W-1:0] rtag;
    logic                 ren;
    reg_addr_t            rn_addr;
    tag_t                 rn_tag;
    logic                 cen;
    reg_addr_t            c_addr;
    tag_t                 c_tag;
    logic [XLEN-1:0]      c_data;
    logic                 flush;
    logic [NREG-1:0]      busy_vec;
`ifdef REGFILE_RAT_BUSYCNT_EN
    logic [AW:0]          busy_cnt;
`endif

    regfile_rat #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .TAG_W(TAG_W), .NRD(NRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .rtag     (rtag),
        .ren      (ren),
        .rn_addr  (rn_addr),
        .rn_tag   (rn_tag),
        .cen      (cen),
        .c_addr   (c_addr),
        .c_tag    (c_tag),
        .c_data   (c_data),
        .flush    (flush),
        .busy_vec (busy_vec)
`ifdef REGFILE_RAT_BUSYCNT_EN
        ,
        .busy_cnt (busy_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural view as plain arrays.
    logic [XLEN-1:0] m_val [NREG];
    logic [NREG-1:0] m_busy;
    tag_t            m_tag [NREG];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NREG); i++) begin
            m_val[i] = '0;
            m_tag[i] = '0;
        end
        m_busy = '0;
    endtask

    task automatic drive_idle();
        rdy     = 1'b1;
        ren     = 1'b0;
        rn_addr = '0;
        rn_tag  = '0;
        cen     = 1'b0;
        c_addr  = '0;
        c_tag   = '0;
        c_data  = '0;
        flush   = 1'b0;
        raddr   = '0;
    endtask

    task automatic exp_read(input reg_addr_t a, output logic [XLEN-1:0] d, output logic b,
                            output tag_t t, output logic byp);
        byp = 1'b0;
        if (a == 0) begin
            d = '0; b = 1'b0; t = '0;
        end else if (cen && c_addr == a && m_busy[a] && m_tag[a] == c_tag) begin
            d = c_data; b = 1'b0; t = '0; byp = 1'b1;
        end else begin
            d = m_val[a]; b = m_busy[a]; t = m_tag[a];
        end
    endtask

    task automatic check_reads();
        reg_addr_t       a;
        logic [XLEN-1:0] d;
        logic            b;
        tag_t            t;
        logic            byp;
        for (int k = 0; k < int'(NRD); k++) begin
            a = raddr[k*AW +: AW];
            exp_read(a, d, b, t, byp);
            check_eq($sformatf("rd%0d_x%0d_data", k, a), 64'(rdata[k*XLEN +: XLEN]), 64'(d));
            check_eq($sformatf("rd%0d_x%0d_busy", k, a), 64'(rbusy[k]), 64'(b));
            if (!byp)
                check_eq($sformatf("rd%0d_x%0d_tag", k, a), 64'(rtag[k*TAG_W +: TAG_W]), 64'(t));
        end
    endtask

    task automatic check_state();
        check_eq("busy_vec", 64'(busy_vec), 64'(m_busy));
`ifdef REGFILE_RAT_BUSYCNT_EN
        check_eq("busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
`endif
    endtask

    task automatic model_step();
        logic rn_ok;
        if (rdy) begin
            rn_ok = ren && !flush && rn_addr != 0;
            if (cen && c_addr != 0) begin
                m_val[c_addr] = c_data;
                if (m_tag[c_addr] == c_tag && !(rn_ok && rn_addr == c_addr))
                    m_busy[c_addr] = 1'b0;
            end
            if (rn_ok) begin
                m_busy[rn_addr] = 1'b1;
                m_tag[rn_addr]  = rn_tag;
            end
            if (flush) begin
                m_busy = '0;
                for (int i = 0; i < int'(NREG); i++) m_tag[i] = '0;
            end
        end
    endtask

    // Check live outputs against the model, clock once, advance the model; returns at negedge.
    task automatic cycle();
        #1;
        check_reads();
        check_state();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic peek(input reg_addr_t a, input logic [XLEN-1:0] d, input logic b,
                        input tag_t t, input string nm);
        drive_idle();
        raddr[AW-1:0] = a;
        #1;
        check_eq({nm, "_data"}, 64'(rdata[XLEN-1:0]), 64'(d));
        check_eq({nm, "_busy"}, 64'(rbusy[0]), 64'(b));
        if (b) check_eq({nm, "_tag"}, 64'(rtag[TAG_W-1:0]), 64'(t));
        cycle();
    endtask

    task automatic do_rename(input reg_addr_t a, input tag_t t);
        drive_idle();
        ren = 1'b1; rn_addr = a; rn_tag = t;
        cycle();
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();
        raddr[AW-1:0] = 5'd5;
        #2;
        check_eq("rst_x5_data", 64'(rdata[XLEN-1:0]), 64'd0);
        check_eq("rst_x5_busy", 64'(rbusy[0]), 64'd0);
        check_eq("rst_x5_tag", 64'(rtag[TAG_W-1:0]), 64'd0);
        check_eq("rst_busy_vec", 64'(busy_vec), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        peek(5'd5, 32'h0, 1'b0, 4'd0, "x5_after_rst");

        // Rename then commit with bypass on channel 1.
        do_rename(5'd3, 4'd7);
        peek(5'd3, 32'h0, 1'b1, 4'd7, "x3_renamed");
        drive_idle();
        cen = 1'b1; c_addr = 5'd3; c_tag = 4'd7; c_data = 32'hDEADBEEF;
        raddr[AW +: AW] = 5'd3;
        #1;
        check_eq("x3_bypass_data", 64'(rdata[XLEN +: XLEN]), 64'hDEADBEEF);
        check_eq("x3_bypass_busy", 64'(rbusy[1]), 64'd0);
        cycle();
        peek(5'd3, 32'hDEADBEEF, 1'b0, 4'd0, "x3_committed");

        // Stale commit after re-rename.
        do_rename(5'd4, 4'd2);
        do_rename(5'd4, 4'd5);
        drive_idle();
        cen = 1'b1; c_addr = 5'd4; c_tag = 4'd2; c_data = 32'h11;
        cycle();
        peek(5'd4, 32'h11, 1'b1, 4'd5, "x4_stale");
`ifdef REGFILE_RAT_BUSYCNT_EN
        check_eq("x4_busy_cnt", 64'(busy_cnt), 64'd1);
`endif

        // Same-cycle commit and rename of x6.
        do_rename(5'd6, 4'd1);
        drive_idle();
        cen = 1'b1; c_addr = 5'd6; c_tag = 4'd1; c_data = 32'h6666;
        ren = 1'b1; rn_addr = 5'd6; rn_tag = 4'd9;
        cycle();
        peek(5'd6, 32'h6666, 1'b1, 4'd9, "x6_rn_cm");

        // Flush with a concurrent rename.
        do_rename(5'd1, 4'd1);
        do_rename(5'd2, 4'd2);
        do_rename(5'd7, 4'd3);
        drive_idle();
        flush = 1'b1; ren = 1'b1; rn_addr = 5'd8; rn_tag = 4'd4;
        cycle();
        #1;
        check_eq("flush_busy_vec", 64'(busy_vec), 64'd0);
`ifdef REGFILE_RAT_BUSYCNT_EN
        check_eq("flush_busy_cnt", 64'(busy_cnt), 64'd0);
`endif
        peek(5'd8, 32'h0, 1'b0, 4'd0, "x8_flushed");
        peek(5'd3, 32'hDEADBEEF, 1'b0, 4'd0, "x3_kept");

        // rdy low freezes state.
        drive_idle();
        rdy = 1'b0;
        ren = 1'b1; rn_addr = 5'd9; rn_tag = 4'd3;
        cen = 1'b1; c_addr = 5'd10; c_tag = 4'd0; c_data = 32'hAA;
        cycle();
        peek(5'd9, 32'h0, 1'b0, 4'd0, "x9_nordy");
        peek(5'd10, 32'h0, 1'b0, 4'd0, "x10_nordy");

        // x0 ignores rename and commit.
        drive_idle();
        ren = 1'b1; rn_addr = 5'd0; rn_tag = 4'd5;
        cen = 1'b1; c_addr = 5'd0; c_tag = 4'd0; c_data = 32'h55;
        cycle();
        peek(5'd0, 32'h0, 1'b0, 4'd0, "x0_ignored");

        // Randomized traffic over a small register window to force collisions.
        for (int it = 0; it < 400; it++) begin
            rdy     = ($urandom_range(0, 9) != 0);
            ren     = 1'($urandom_range(0, 1));
            rn_addr = reg_addr_t'($urandom_range(0, 7));
            rn_tag  = tag_t'($urandom_range(0, 15));
            cen     = 1'($urandom_range(0, 1));
            c_addr  = reg_addr_t'($urandom_range(0, 7));
            c_tag   = ($urandom_range(0, 3) != 0) ? m_tag[c_addr] : tag_t'($urandom_range(0, 15));
            c_data  = $urandom;
            flush   = ($urandom_range(0, 19) == 0);
            raddr[AW-1:0]   = ($urandom_range(0, 1) != 0) ? c_addr : reg_addr_t'($urandom_range(0, 7));
            raddr[AW +: AW] = reg_addr_t'($urandom_range(0, 31));
            cycle();
        end

        // Asynchronous reset between clock edges.
        drive_idle();
        cen = 1'b1; c_addr = 5'd3; c_tag = m_tag[3]; c_data = 32'h1234;
        cycle();
        do_rename(5'd5, 4'd3);
        drive_idle();
        raddr[AW-1:0]   = 5'd3;
        raddr[AW +: AW] = 5'd5;
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_x3_data", 64'(rdata[XLEN-1:0]), 64'd0);
        check_eq("async_rst_x5_busy", 64'(rbusy[1]), 64'd0);
        check_eq("async_rst_busy_vec", 64'(busy_vec), 64'd0);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        peek(5'd3, 32'h0, 1'b0, 4'd0, "post_rst_x3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
